controle_soma: RTL

Sequencing controller for the element-wise matrix add/subtract datapath of the matrix coprocessor. On a start command it walks a square sub-matrix of runtime dimension `dim`. For each element it reads operand A and operand B from a shared single-port matrix memory, computes the 8-bit sum or difference, and writes the result to the C region. It owns the memory port for the whole operation and reports completion, overflow and command errors to the host-side control logic.

---
 rtl/controle_soma.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/controle_soma.sv
// Sequencer for element-wise matrix add/subtract over a shared single-port memory.
// Walks an n x n sub-block row-major: read A, read B, capture B, write C per element.
module controle_soma #(
  parameter int TAMANHO = 5,
  parameter int BASE_A  = 0,
  parameter int BASE_B  = 25,
  parameter int BASE_C  = 50,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic [2:0]        dim,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        i_q, i_d;
  logic [2:0]        j_q, j_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic [8:0]        res_wr;
  logic [8:0]        res_cap;
  logic              last_col;
  logic              last_row;

  // Word address of element (i, j) in a region with row stride TAMANHO.
  function automatic logic [ADDR_W-1:0] elem_addr(
    input logic [ADDR_W-1:0] base,
    input logic [2:0]        i,
    input logic [2:0]        j
  );
    logic [ADDR_W-1:0] row;
    row = ADDR_W'(i) * ADDR_W'(TAMANHO);
    return base + row + ADDR_W'(j);
  endfunction

  // 9-bit add/sub; bit 8 is the carry (add) or the unsigned borrow (sub).
  function automatic logic [8:0] alu_wrap(
    input logic       sub,
    input logic [7:0] a,
    input logic [7:0] b
  );
    if (sub) begin
      return {1'b0, a} - {1'b0, b};
    end
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign res_wr   = alu_wrap(op_q, a_q, b_q);
  assign res_cap  = alu_wrap(op_q, a_q, mem_rdata);
  assign last_col = (j_q == n_q - 3'd1);
  assign last_row = (i_q == n_q - 3'd1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    n_d     = n_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    ovf_d   = ovf_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          n_d   = dim;
          i_d   = 3'd0;
          j_d   = 3'd0;
          ovf_d = 1'b0;
          if ((dim == 3'd0) || (int'(dim) > TAMANHO)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RD_A;
          end
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d     = mem_rdata;
        state_d = CAP_B;
      end
      CAP_B: begin
        b_d     = mem_rdata;
        state_d = WR;
      end
      WR: begin
        ovf_d = ovf_q | res_wr[8];
        if (last_col && last_row) begin
          state_d = DONE;
        end else if (last_col) begin
          j_d     = 3'd0;
          i_d     = i_q + 3'd1;
          state_d = RD_A;
        end else begin
          j_d     = j_q + 3'd1;
          state_d = RD_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_rd_d    = (state_d == RD_A) || (state_d == RD_B);
    mem_we_d    = (state_d == WR);
    mem_addr_d  = '0;
    mem_wdata_d = 8'd0;
    case (state_d)
      RD_A:    mem_addr_d = elem_addr(ADDR_W'(BASE_A), i_d, j_d);
      RD_B:    mem_addr_d = elem_addr(ADDR_W'(BASE_B), i_d, j_d);
      WR: begin
        mem_addr_d  = elem_addr(ADDR_W'(BASE_C), i_d, j_d);
        mem_wdata_d = res_cap[7:0];
      end
      default: mem_addr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      n_q         <= 3'd0;
      i_q         <= 3'd0;
      j_q         <= 3'd0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      n_q         <= n_d;
      i_q         <= i_d;
      j_q         <= j_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Operand registers are pure data and are always overwritten before use.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule
